// File: rtl/sang_dan_pkg.sv
// Shared types and constants for the sang_dan LED-chaser controller.
// Optional speed feature is enabled with macro SANG_DAN_SPEED_EN.
package sang_dan_pkg;

  localparam int unsigned DB_CYCLES_DEF = 250000;
  localparam int unsigned TICK_DIV_DEF  = 12500000;
  localparam int unsigned SPEED_W       = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  // Divider after applying a speed shift; never lets the period collapse to 0.
  function automatic int unsigned eff_div(input int unsigned div, input logic [SPEED_W-1:0] spd);
    int unsigned d;
    d = div >> spd;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/sang_dan_ctrl_if.sv
// Button inputs and chaser control outputs of sang_dan_ctrl.
// btn_speed exists only when SANG_DAN_SPEED_EN is defined.
interface sang_dan_ctrl_if;
  logic btn_ss;
  logic btn_mode;
`ifdef SANG_DAN_SPEED_EN
  logic btn_speed;
`endif
  logic SS;
  logic MODE;
  logic step;

`ifdef SANG_DAN_SPEED_EN
  modport master (output btn_ss, output btn_mode, output btn_speed,
                  input SS, input MODE, input step);
  modport slave  (input btn_ss, input btn_mode, input btn_speed,
                  output SS, output MODE, output step);
`else
  modport master (output btn_ss, output btn_mode,
                  input SS, input MODE, input step);
  modport slave  (input btn_ss, input btn_mode,
                  output SS, output MODE, output step);
`endif
endinterface

// File: rtl/sang_dan.sv
// Top-level RTL for this block is module sang_dan_ctrl in rtl/sang_dan_ctrl.sv.

// File: rtl/sang_dan_debounce.sv
// Two-flop synchronizer plus debounce FSM for one pushbutton.
// press is a combinational one-cycle pulse so the consumer's register
// toggles on the same edge the FSM enters HELD.
module sang_dan_debounce
  import sang_dan_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronize the raw asynchronous button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // FSM state and stable-time counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and press event
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/sang_dan_ctrl.sv
// LED-chaser controller: debounced start/stop and mode toggles, step-pulse divider.
// Define SANG_DAN_SPEED_EN to add a speed button selecting divider TICK_DIV>>speed.
module sang_dan_ctrl
  import sang_dan_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
  input  logic            clk,
  input  logic            reset,
  sang_dan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST_DEF = CNT_W'(TICK_DIV - 1);

  logic             press_ss;
  logic             press_mode;
  logic             ss_q, ss_d;
  logic             mode_q, mode_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] tick_last;
  logic             cnt_clear;

  sang_dan_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_ss),
    .press (press_ss)
  );

  sang_dan_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_mode),
    .press (press_mode)
  );

`ifdef SANG_DAN_SPEED_EN
  logic               press_speed;
  logic [SPEED_W-1:0] speed_q, speed_d;

  sang_dan_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_speed (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.btn_speed),
    .press (press_speed)
  );
`endif

  // Control and divider registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_q       <= 1'b0;
      mode_q     <= 1'b0;
      step_q     <= 1'b0;
      tick_cnt_q <= '0;
`ifdef SANG_DAN_SPEED_EN
      speed_q    <= '0;
`endif
    end else begin
      ss_q       <= ss_d;
      mode_q     <= mode_d;
      step_q     <= step_d;
      tick_cnt_q <= tick_cnt_d;
`ifdef SANG_DAN_SPEED_EN
      speed_q    <= speed_d;
`endif
    end
  end

  // Toggles, counter restart and step generation
  always_comb begin
    ss_d      = ss_q ^ press_ss;
    mode_d    = mode_q ^ press_mode;
    cnt_clear = press_mode;
    tick_last = TICK_LAST_DEF;
`ifdef SANG_DAN_SPEED_EN
    speed_d   = speed_q + SPEED_W'(press_speed);
    cnt_clear = press_mode | press_speed;
    tick_last = CNT_W'(eff_div(TICK_DIV, speed_q) - 1);
`endif
    // Counter restarts from 0 whenever SS is (or is becoming) low, or on a pattern/speed change
    if (!ss_q || !ss_d || cnt_clear) begin
      tick_cnt_d = '0;
    end else if (tick_cnt_q == tick_last) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + CNT_W'(1);
    end
    // Gating on ss_d keeps step low in the cycle after SS falls
    step_d = ss_q && ss_d && !cnt_clear && (tick_cnt_q == tick_last);
  end

  assign bus.SS   = ss_q;
  assign bus.MODE = mode_q;
  assign bus.step = step_q;

endmodule
